// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg
// Shared definitions for the memory-access stage: operation codes, reset /
// stall / write-enable levels, FSM state encoding, and small op-class helpers.
package mem_stage_pkg;

  localparam logic RST_ENABLE    = 1'b1;
  localparam logic STALL_ENABLE  = 1'b1;
  localparam logic STALL_DISABLE = 1'b0;
  localparam logic WRITE_ENABLE  = 1'b1;
  localparam logic WRITE_DISABLE = 1'b0;

  localparam logic [7:0] OP_NULL = 8'h00;
  localparam logic [7:0] OP_ADD  = 8'h01;
  localparam logic [7:0] OP_LB   = 8'h20;
  localparam logic [7:0] OP_LH   = 8'h21;
  localparam logic [7:0] OP_LW   = 8'h23;
  localparam logic [7:0] OP_LBU  = 8'h24;
  localparam logic [7:0] OP_LHU  = 8'h25;
  localparam logic [7:0] OP_SB   = 8'h28;
  localparam logic [7:0] OP_SH   = 8'h29;
  localparam logic [7:0] OP_SW   = 8'h2B;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'b00,
    MEM_BUSY = 2'b01,
    MEM_DONE = 2'b10
  } mem_state_e;

  function automatic logic is_store_op(input logic [7:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic is_load_op(input logic [7:0] op);
    return (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) ||
           (op == OP_LHU) || (op == OP_LW);
  endfunction

  function automatic logic is_mem_op(input logic [7:0] op);
    return is_load_op(op) || is_store_op(op);
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if
// Data-memory bus between the memory stage (master) and the memory (slave).
//   req   : request, held until the cycle after ack
//   we    : write strobe, valid with req
//   addr  : word-aligned byte address
//   sel   : byte-lane enables, lane i = bits 8i+7:8i
//   wdata : store data, replicated into lanes
//   ack   : single-cycle acknowledge from the slave
//   rdata : read data, valid with ack
interface mem_stage_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  sel;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;

  modport master (
    output req, we, addr, sel, wdata,
    input  ack, rdata
  );

  modport slave (
    input  req, we, addr, sel, wdata,
    output ack, rdata
  );
endinterface

// File: rtl/mem_align.sv
// mem_align
// Combinational byte-lane logic for the memory stage.
//   op         : operation code in MEM
//   addr_lo    : low two address bits
//   store_data : raw store operand
//   load_word  : latched 32-bit word returned by the bus
//   load_data  : extracted and sign/zero-extended load result
//   sel        : byte-lane enables for the access size and lane
//   wdata      : store data replicated into every lane of its size
//   misaligned : halfword on an odd address, or word not on a 4-byte boundary
module mem_align
  import mem_stage_pkg::*;
(
  input  logic [7:0]  op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] load_word,
  output logic [31:0] load_data,
  output logic [3:0]  sel,
  output logic [31:0] wdata,
  output logic        misaligned
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [3:0]  half_sel;

  always_comb begin
    lane_byte = load_word[{addr_lo, 3'b000} +: 8];
    lane_half = addr_lo[1] ? load_word[31:16] : load_word[15:0];
    half_sel  = addr_lo[1] ? 4'b1100 : 4'b0011;
  end

  always_comb begin
    load_data  = load_word;
    sel        = 4'b0000;
    wdata      = store_data;
    misaligned = 1'b0;
    case (op)
      OP_LB, OP_LBU, OP_SB: begin
        sel   = 4'b0001 << addr_lo;
        wdata = {4{store_data[7:0]}};
        if (op == OP_LB) load_data = {{24{lane_byte[7]}}, lane_byte};
        else             load_data = {24'h0, lane_byte};
      end
      OP_LH, OP_LHU, OP_SH: begin
        misaligned = addr_lo[0];
        sel        = half_sel;
        wdata      = {2{store_data[15:0]}};
        if (op == OP_LH) load_data = {{16{lane_half[15]}}, lane_half};
        else             load_data = {16'h0, lane_half};
      end
      OP_LW, OP_SW: begin
        misaligned = |addr_lo;
        sel        = 4'b1111;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// mem_stage
// Memory-access stage. Runs loads/stores on the data bus with a req/ack
// handshake, holds the pipeline via stallreq_mem while a transaction is open,
// and presents write-back fields to MEM/WB. Non-memory ops pass straight
// through combinationally.
//   clk, rst        : clock, synchronous active-high reset
//   stall           : stall vector; bit 4 holds MEM/WB
//   mem_*           : EX/MEM register contents (op, address/ALU result,
//                     store data, write enable/address/data)
//   dmem            : data-memory bus, master side (bus outputs registered)
//   stallreq_mem    : stall request while a transaction is in flight
//   wb_*            : write-back fields to MEM/WB
//   mem_misaligned  : misaligned-access flag to the exception logic
//
// state | meaning
// IDLE  | no transaction; an aligned memory op loads the bus and requests a stall
// BUSY  | request on the bus, fields held stable, waiting for ack
// DONE  | read data latched; result presented until MEM/WB is released
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         stall,
  input  logic [31:0]        mem_instr,
  input  logic [7:0]         mem_op,
  input  logic [31:0]        mem_reg1,
  input  logic [31:0]        mem_reg2,
  input  logic               mem_we,
  input  logic [4:0]         mem_write_addr,
  input  logic [31:0]        mem_write_instr,
  mem_stage_if.master        dmem,
  output logic               stallreq_mem,
  output logic               wb_we,
  output logic [4:0]         wb_write_addr,
  output logic [31:0]        wb_write_data,
  output logic               mem_misaligned
);

  mem_state_e  state_q, state_d;
  logic        req_q, we_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [3:0]  sel_q;

  logic        mem_access, store_access, issue, load_bus;
  logic [31:0] load_data, lane_wdata;
  logic [3:0]  lane_sel;
  logic        misaligned_raw;

  // The instruction word and the other stall bits are not needed here.
  logic unused_inputs;
  assign unused_inputs = ^{mem_instr, stall[5], stall[3:0]};

  mem_align u_align (
    .op         (mem_op),
    .addr_lo    (mem_reg1[1:0]),
    .store_data (mem_reg2),
    .load_word  (rdata_q),
    .load_data  (load_data),
    .sel        (lane_sel),
    .wdata      (lane_wdata),
    .misaligned (misaligned_raw)
  );

  assign mem_access   = is_mem_op(mem_op);
  assign store_access = is_store_op(mem_op);
  assign issue        = mem_access && !misaligned_raw;

  always_comb begin
    state_d      = state_q;
    stallreq_mem = 1'b0;
    load_bus     = 1'b0;
    case (state_q)
      MEM_IDLE: begin
        if (issue) begin
          stallreq_mem = 1'b1;
          load_bus     = 1'b1;
          state_d      = MEM_BUSY;
        end
      end
      MEM_BUSY: begin
        stallreq_mem = 1'b1;
        if (dmem.ack) state_d = MEM_DONE;
      end
      MEM_DONE: begin
        if (stall[4] == STALL_DISABLE) state_d = MEM_IDLE;
      end
      default: state_d = MEM_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state_q <= MEM_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      sel_q   <= 4'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      if (load_bus) begin
        req_q   <= 1'b1;
        we_q    <= store_access;
        addr_q  <= {mem_reg1[31:2], 2'b00};
        sel_q   <= lane_sel;
        wdata_q <= lane_wdata;
      end else if (state_q == MEM_BUSY && dmem.ack) begin
        // Address/lanes stay put after the handshake; only the strobes drop.
        req_q   <= 1'b0;
        we_q    <= 1'b0;
        rdata_q <= dmem.rdata;
      end
    end
  end

  assign dmem.req   = req_q;
  assign dmem.we    = we_q;
  assign dmem.addr  = addr_q;
  assign dmem.sel   = sel_q;
  assign dmem.wdata = wdata_q;

  // A misaligned access is squashed here; the exception logic takes it from
  // mem_misaligned. Stores keep whatever enable EX supplied (normally 0).
  always_comb begin
    mem_misaligned = mem_access && misaligned_raw;
    wb_write_addr  = mem_write_addr;
    wb_we          = mem_misaligned ? WRITE_DISABLE : mem_we;
    wb_write_data  = mem_write_instr;
    if (state_q == MEM_DONE && is_load_op(mem_op)) wb_write_data = load_data;
  end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
  import mem_stage_pkg::*;

  typedef struct packed {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        mis;
  } wb_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
  } bus_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic [31:0] mem_instr, mem_reg1, mem_reg2, mem_write_instr;
  logic [7:0]  mem_op;
  logic        mem_we;
  logic [4:0]  mem_write_addr;
  logic        stallreq_mem, wb_we, mem_misaligned;
  logic [4:0]  wb_write_addr;
  logic [31:0] wb_write_data;

  mem_stage_if bus ();

  mem_stage dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .mem_instr       (mem_instr),
    .mem_op          (mem_op),
    .mem_reg1        (mem_reg1),
    .mem_reg2        (mem_reg2),
    .mem_we          (mem_we),
    .mem_write_addr  (mem_write_addr),
    .mem_write_instr (mem_write_instr),
    .dmem            (bus.master),
    .stallreq_mem    (stallreq_mem),
    .wb_we           (wb_we),
    .wb_write_addr   (wb_write_addr),
    .wb_write_data   (wb_write_data),
    .mem_misaligned  (mem_misaligned)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  wb_t  wb_q[$];
  bus_t bus_q[$];

  int          ack_cycle = 1;
  logic [31:0] slave_rdata = 32'h0;
  logic        stray_ack = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory slave: acks in the ack_cycle-th cycle of an open request.
  initial begin
    int k;
    k = 0;
    bus.ack   = 1'b0;
    bus.rdata = 32'h0;
    forever begin
      @(negedge clk);
      bus.ack = stray_ack;
      if (bus.req && !rst) begin
        k++;
        if (k == ack_cycle) begin
          bus.ack   = 1'b1;
          bus.rdata = slave_rdata;
        end
      end else begin
        k = 0;
      end
    end
  end

  // Bus monitor: checks each new request and that it stays stable.
  initial begin
    bus_t cur;
    logic prev_req;
    prev_req = 1'b0;
    cur = '0;
    forever begin
      @(negedge clk);
      if (bus.req && !prev_req) begin
        if (bus_q.size() == 0) begin
          check("bus_unexpected_req", 32'd1, 32'd0);
        end else begin
          cur = bus_q.pop_front();
          check("bus_we", {31'h0, bus.we}, {31'h0, cur.we});
          check("bus_addr", bus.addr, cur.addr);
          check("bus_sel", {28'h0, bus.sel}, {28'h0, cur.sel});
          check("bus_wdata", bus.wdata, cur.wdata);
        end
      end else if (bus.req && prev_req) begin
        check("bus_stable_addr", bus.addr, cur.addr);
        check("bus_stable_sel", {28'h0, bus.sel}, {28'h0, cur.sel});
        check("bus_stable_wdata", bus.wdata, cur.wdata);
        check("bus_stable_we", {31'h0, bus.we}, {31'h0, cur.we});
      end
      prev_req = bus.req;
    end
  end

  // Write-back monitor: MEM/WB captures when MEM does not stall and is released.
  initial begin
    wb_t e;
    forever begin
      @(negedge clk);
      if (!rst && mem_op != OP_NULL && !stallreq_mem && !stall[4]) begin
        if (wb_q.size() == 0) begin
          check("wb_unexpected", 32'd1, 32'd0);
        end else begin
          e = wb_q.pop_front();
          check("wb_we", {31'h0, wb_we}, {31'h0, e.we});
          check("wb_write_addr", {27'h0, wb_write_addr}, {27'h0, e.addr});
          check("wb_write_data", wb_write_data, e.data);
          check("mem_misaligned", {31'h0, mem_misaligned}, {31'h0, e.mis});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Issue one op at posedge+1; returns at posedge+1 after MEM/WB captured it.
  task automatic run_op(input string name, input logic [7:0] op, input logic [31:0] addr,
                        input logic [31:0] sdata, input logic we, input logic [4:0] waddr,
                        input logic [31:0] winstr, input int ack_c, input logic [31:0] rdata,
                        input int hold, input wb_t exp_wb, input bus_t exp_bus,
                        input int exp_stall);
    int cycles;
    mem_op          = op;
    mem_reg1        = addr;
    mem_reg2        = sdata;
    mem_we          = we;
    mem_write_addr  = waddr;
    mem_write_instr = winstr;
    mem_instr       = 32'h0;
    ack_cycle       = ack_c;
    slave_rdata     = rdata;
    stall           = (hold > 0) ? 6'b010000 : 6'b000000;
    wb_q.push_back(exp_wb);
    if (exp_stall > 0) bus_q.push_back(exp_bus);
    cycles = 0;
    forever begin
      @(negedge clk);
      if (!stallreq_mem) break;
      cycles++;
      if (cycles > 50) begin
        check({name, "_stall_timeout"}, 32'd1, 32'd0);
        break;
      end
      @(posedge clk); #1;
    end
    check({name, "_stall_cycles"}, cycles, exp_stall);
    if (hold > 0) begin
      repeat (hold - 1) begin
        @(posedge clk);
        @(negedge clk);
        check({name, "_hold_stallreq"}, {31'h0, stallreq_mem}, 32'd0);
      end
      @(posedge clk); #1;
      stall = 6'b000000;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    stall = 6'h0;
    mem_instr = 32'h0;
    mem_op = OP_NULL;
    mem_reg1 = 32'h0;
    mem_reg2 = 32'h0;
    mem_we = 1'b0;
    mem_write_addr = 5'h0;
    mem_write_instr = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req", {31'h0, bus.req}, 32'd0);
    check("rst_we", {31'h0, bus.we}, 32'd0);
    check("rst_addr", bus.addr, 32'd0);
    check("rst_sel", {28'h0, bus.sel}, 32'd0);
    check("rst_wdata", bus.wdata, 32'd0);
    check("rst_stallreq", {31'h0, stallreq_mem}, 32'd0);
    check("rst_wb_we", {31'h0, wb_we}, 32'd0);
    check("rst_wb_addr", {27'h0, wb_write_addr}, 32'd0);
    check("rst_wb_data", wb_write_data, 32'd0);
    check("rst_misaligned", {31'h0, mem_misaligned}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_op("lw", OP_LW, 32'h100, 32'h0, 1'b1, 5'd3, 32'h0, 1, 32'hDEADBEEF, 0,
           '{1'b1, 5'd3, 32'hDEADBEEF, 1'b0}, '{1'b0, 32'h100, 4'hF, 32'h0}, 2);
    run_op("lb", OP_LB, 32'h103, 32'h0, 1'b1, 5'd4, 32'h0, 1, 32'h80AA55CC, 0,
           '{1'b1, 5'd4, 32'hFFFFFF80, 1'b0}, '{1'b0, 32'h100, 4'b1000, 32'h0}, 2);
    run_op("lbu", OP_LBU, 32'h103, 32'h0, 1'b1, 5'd4, 32'h0, 1, 32'h80AA55CC, 2,
           '{1'b1, 5'd4, 32'h00000080, 1'b0}, '{1'b0, 32'h100, 4'b1000, 32'h0}, 2);
    run_op("add", OP_ADD, 32'h0, 32'h0, 1'b1, 5'd5, 32'h42, 0, 32'h0, 0,
           '{1'b1, 5'd5, 32'h42, 1'b0}, '0, 0);
    run_op("sh", OP_SH, 32'h102, 32'h1234ABCD, 1'b0, 5'd0, 32'h77, 4, 32'h0, 0,
           '{1'b0, 5'd0, 32'h77, 1'b0}, '{1'b1, 32'h100, 4'b1100, 32'hABCDABCD}, 5);
    run_op("lw_mis", OP_LW, 32'h101, 32'h0, 1'b1, 5'd6, 32'h99, 1, 32'h0, 0,
           '{1'b0, 5'd6, 32'h99, 1'b1}, '0, 0);
    run_op("lh", OP_LH, 32'h102, 32'h0, 1'b1, 5'd7, 32'h0, 2, 32'h80017FFF, 0,
           '{1'b1, 5'd7, 32'hFFFF8001, 1'b0}, '{1'b0, 32'h100, 4'b1100, 32'h0}, 3);
    run_op("lhu", OP_LHU, 32'h100, 32'h0, 1'b1, 5'd8, 32'h0, 1, 32'h8001F00F, 0,
           '{1'b1, 5'd8, 32'h0000F00F, 1'b0}, '{1'b0, 32'h100, 4'b0011, 32'h0}, 2);
    run_op("sb", OP_SB, 32'h201, 32'h000000A5, 1'b0, 5'd0, 32'h0, 1, 32'h0, 0,
           '{1'b0, 5'd0, 32'h0, 1'b0}, '{1'b1, 32'h200, 4'b0010, 32'hA5A5A5A5}, 2);
    run_op("sw", OP_SW, 32'h204, 32'hCAFEF00D, 1'b0, 5'd0, 32'h0, 1, 32'h0, 0,
           '{1'b0, 5'd0, 32'h0, 1'b0}, '{1'b1, 32'h204, 4'hF, 32'hCAFEF00D}, 2);
    run_op("lh_mis", OP_LH, 32'h103, 32'h0, 1'b1, 5'd9, 32'h55, 1, 32'h0, 0,
           '{1'b0, 5'd9, 32'h55, 1'b1}, '0, 0);

    // Reset while BUSY, then a late ack that must be ignored.
    mem_op = OP_LW;
    mem_reg1 = 32'h300;
    mem_reg2 = 32'h0;
    mem_we = 1'b1;
    mem_write_addr = 5'd10;
    mem_write_instr = 32'h0;
    ack_cycle = 100;
    bus_q.push_back('{1'b0, 32'h300, 4'hF, 32'h0});
    @(negedge clk);
    check("rst_mid_stallreq_c0", {31'h0, stallreq_mem}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_req_c1", {31'h0, bus.req}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    mem_op = OP_NULL;
    mem_reg1 = 32'h0;
    mem_we = 1'b0;
    mem_write_addr = 5'd0;
    stray_ack = 1'b1;
    @(negedge clk);
    check("rst_mid_req", {31'h0, bus.req}, 32'd0);
    check("rst_mid_we", {31'h0, bus.we}, 32'd0);
    check("rst_mid_addr", bus.addr, 32'd0);
    check("rst_mid_sel", {28'h0, bus.sel}, 32'd0);
    check("rst_mid_wdata", bus.wdata, 32'd0);
    check("rst_mid_stallreq", {31'h0, stallreq_mem}, 32'd0);
    check("rst_mid_wb_we", {31'h0, wb_we}, 32'd0);
    check("rst_mid_wb_data", wb_write_data, 32'd0);
    @(posedge clk); #1;
    stray_ack = 1'b0;
    @(negedge clk);
    check("late_ack_req", {31'h0, bus.req}, 32'd0);
    @(posedge clk); #1;

    // A fresh load must see the full IDLE->BUSY->DONE sequence.
    run_op("lw_after_rst", OP_LW, 32'h104, 32'h0, 1'b1, 5'd11, 32'h0, 1, 32'h13579BDF, 0,
           '{1'b1, 5'd11, 32'h13579BDF, 1'b0}, '{1'b0, 32'h104, 4'hF, 32'h0}, 2);

    mem_op = OP_NULL;
    mem_we = 1'b0;
    repeat (4) @(posedge clk);
    check("wb_queue_left", wb_q.size(), 32'd0);
    check("bus_queue_left", bus_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
